uart_rx_ctrl: RTL and testbench

- UART receive controller for the image-receiver path.
- Owns and sequences a bit-timing counter: held cleared in idle, restarted on each start edge, sampled mid-bit.
- Deframes 8N1 serial data into bytes and hands them to downstream image logic over a valid/ready handshake, with error flags.

---
 rtl/uart_rx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with a valid/ready byte output and sticky error flags; define UART_RX_PARITY_EN for 8E1 with parity_err
module uart_rx_ctrl #(
  parameter int clk_hz = 12000000,
  parameter int baud   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);
  localparam int BIT  = clk_hz / baud;
  localparam int HALF = BIT >> 1;
  localparam int CW   = $clog2(BIT);
`ifdef UART_RX_PARITY_EN
  localparam int IW   = 4;
`else
  localparam int IW   = 3;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            s1_q, s2_q, rs_prev_q;
  logic            rs, tick_bit, tick_half, done, ferr_set, load;
`ifdef UART_RX_PARITY_EN
  logic            perr_q, perr_d, perr_set;
`endif

  assign rs        = s2_q;
  assign tick_bit  = cnt_q == CW'(BIT - 1);
  assign tick_half = cnt_q == CW'(HALF - 1);

  // Two-flop synchroniser on the line plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {s1_q, s2_q, rs_prev_q} <= 3'b111;
    else {s1_q, s2_q, rs_prev_q} <= {rx, s1_q, s2_q};
  end

  // Frame sequencing: bit-timing counter, bit index and shift register
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    sh_d     = sh_q;
    done     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state_q)
      IDLE: if (rs_prev_q && !rs) state_d = START;
      START: begin
        cnt_d = tick_half ? '0 : cnt_q + 1'b1;
        if (tick_half) begin
          state_d = rs ? IDLE : DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        cnt_d = tick_bit ? '0 : cnt_q + 1'b1;
        if (tick_bit) begin
          sh_d  = {rs, sh_q[7:1]};
          idx_d = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == IW'(7)) state_d = PARITY;
`else
          if (idx_q == IW'(7)) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = tick_bit ? '0 : cnt_q + 1'b1;
        if (tick_bit) begin
          perr_set = rs != ^sh_q;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = tick_bit ? '0 : cnt_q + 1'b1;
        if (tick_bit) begin
          done     = rs;
          ferr_set = !rs;
          state_d  = rs ? IDLE : BREAK;
        end
      end
      BREAK: if (rs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output handshake and sticky flags; a completed byte is dropped if the previous one is still pending
  always_comb begin
    load    = done && (!valid_q || ready);
    data_d  = load ? sh_q : data_q;
    valid_d = load || (valid_q && !ready);
    ovr_d   = (done && valid_q && !ready) || (ovr_q && !clr_err);
    ferr_d  = ferr_set || (ferr_q && !clr_err);
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_set || (perr_q && !clr_err);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = state_q != IDLE;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl at default 12 MHz / 115200 (BIT=104, HALF=52)
module tb_uart_rx_ctrl;
  localparam int BIT  = 104;
  localparam int HALF = 52;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int LAT = HALF + NB * BIT + 1 + 2;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx = 1'b1;
  logic       clr_err = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       bad_par = 1'b0;
`endif
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         t = 0;
  logic       v_prev = 1'b0;
  exp_t       q[$];
  exp_t       e;

  uart_rx_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx(rx),
    .clr_err(clr_err),
    .data(data),
    .valid(valid),
    .ready(ready),
    .busy(busy),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid && !v_prev) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got data 0x%0h at cycle %0d, want no byte", data, cyc);
      end else begin
        e = q.pop_front();
        chk("sb_data", 32'(data), 32'(e.b));
        chk("sb_latency", cyc, e.t);
      end
    end
    v_prev <= valid;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic push);
    exp_t x;
    @(posedge clk);
    #1;
    x.b = b;
    x.t = cyc + LAT;
    if (push) q.push_back(x);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^b ^ bad_par);
`endif
    bit_out(stop);
  endtask

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: run still active at cycle %0d, want finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(5);
    send(8'hA5, 1'b1, 1'b1);
    idle(5);
    chk("a5_valid_done", 32'(valid), 32'h0);
    chk("a5_busy", 32'(busy), 32'h0);
    chk("a5_frame_err", 32'(frame_err), 32'h0);
    chk("a5_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1 rx = 1'b0;
    t = cyc;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    at_cyc(t + 54);
    chk("false_start_busy_last", 32'(busy), 32'h1);
    at_cyc(t + 55);
    chk("false_start_idle", 32'(busy), 32'h0);
    chk("false_start_frame_err", 32'(frame_err), 32'h0);
    chk("false_start_valid", 32'(valid), 32'h0);
    send(8'h3C, 1'b0, 1'b0);
    idle(50);
    chk("break_busy", 32'(busy), 32'h1);
    chk("break_frame_err", 32'(frame_err), 32'h1);
    rx = 1'b1;
    idle(5);
    chk("break_exit_busy", 32'(busy), 32'h0);
    chk("break_exit_frame_err", 32'(frame_err), 32'h1);
    chk("break_valid", 32'(valid), 32'h0);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("clr_frame_err", 32'(frame_err), 32'h0);
    ready = 1'b0;
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b0);
    idle(5);
    chk("ovr_valid", 32'(valid), 32'h1);
    chk("ovr_data_held", 32'(data), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'h1);
    ready = 1'b1;
    idle(1);
    chk("accept_valid", 32'(valid), 32'h0);
    chk("accept_data_kept", 32'(data), 32'h11);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'h0);
    send(8'h55, 1'b1, 1'b1);
    send(8'hAA, 1'b1, 1'b1);
    idle(5);
    chk("b2b_overrun", 32'(overrun), 32'h0);
    chk("b2b_data_last", 32'(data), 32'hAA);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_data", 32'(data), 32'h00);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(20);
    chk("post_rst_busy", 32'(busy), 32'h0);
`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
`endif
    send(8'h7E, 1'b1, 1'b1);
    idle(5);
    chk("7e_data", 32'(data), 32'h7E);
    chk("7e_frame_err", 32'(frame_err), 32'h0);
`ifdef UART_RX_PARITY_EN
    chk("7e_parity_err", 32'(parity_err), 32'h1);
`endif
    idle(20);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
